// File: rtl/alien_shot_scheduler_pkg.sv
// Shared types and constants for the alien shot scheduler and the shot instances.
package shot_sched_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      SELECT,
      FIRE
   } sched_state_t;

   // Fibonacci taps 16,14,13,11 expressed as a mask over q[15:0]
   localparam logic [15:0] LFSR_TAPS         = 16'hB400;
   localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

   typedef logic signed [10:0] coord_t;

endpackage

// File: rtl/alien_shot_scheduler_if.sv
// Bundle between the alien-grid controller side and the alien shot scheduler.
interface alien_shot_scheduler_if #(
   parameter int NUM_SLOTS   = 3,
   parameter int NUM_COLUMNS = 8
);
   import shot_sched_pkg::*;

   localparam int SLOT_W = $clog2(NUM_SLOTS);

   logic                   startOfFrame;
   logic                   playGame;
   logic                   levelUp;
   logic [NUM_COLUMNS-1:0] aliveColumns;
   coord_t                 alienBaseX;
   coord_t                 alienBottomY;
   coord_t                 playerXPosition;
   logic [NUM_SLOTS-1:0]   slotAlive;
   logic [NUM_SLOTS-1:0]   fireStart;
   coord_t                 fireX;
   coord_t                 fireY;
   logic [SLOT_W-1:0]      fireSlot;

   modport master (
      output startOfFrame, playGame, levelUp, aliveColumns,
      output alienBaseX, alienBottomY, playerXPosition, slotAlive,
      input  fireStart, fireX, fireY, fireSlot
   );

   modport slave (
      input  startOfFrame, playGame, levelUp, aliveColumns,
      input  alienBaseX, alienBottomY, playerXPosition, slotAlive,
      output fireStart, fireX, fireY, fireSlot
   );

endinterface

// File: rtl/alien_shot_scheduler_lfsr16.sv
// 16-bit Fibonacci LFSR that steps every clock outside reset; supplies the random column.
module lfsr16
   import shot_sched_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] seed,
   output logic [15:0] q
);

   logic [15:0] lfsr_q;
   logic        fb;

   assign fb = ^(lfsr_q & LFSR_TAPS);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) lfsr_q <= seed;
      else       lfsr_q <= {lfsr_q[14:0], fb};
   end

   assign q = lfsr_q;

endmodule

// File: rtl/alien_shot_scheduler.sv
// Alien fire sequencer: frame-interval timer, alive-column scan, round-robin slot launch.
// Optional build macro SHOT_SCHED_AIM_EN: odd-numbered shots start the scan at the player's column.
//
// state  | meaning
// IDLE   | not playing; frame timer held at the interval
// WAIT   | counting startOfFrame pulses down to the next fire attempt
// SELECT | scanning from the start column for a column that still has aliens
// FIRE   | picking a free slot and launching the shot
module alien_shot_scheduler
   import shot_sched_pkg::*;
#(
   parameter int          NUM_SLOTS        = 3,
   parameter int          NUM_COLUMNS      = 8,
   parameter int          COLUMN_PITCH     = 64,
   parameter int          SHOT_X_OFFSET    = 28,
   parameter int          INITIAL_INTERVAL = 60,
   parameter int          MIN_INTERVAL     = 15,
   parameter int          INTERVAL_STEP    = 5,
   parameter logic [15:0] LFSR_SEED        = LFSR_DEFAULT_SEED
) (
   input  logic                  clk,
   input  logic                  reset,
   alien_shot_scheduler_if.slave bus
);

   localparam int COL_W    = $clog2(NUM_COLUMNS);
   localparam int SLOT_W   = $clog2(NUM_SLOTS);
   localparam int PITCH_SH = $clog2(COLUMN_PITCH);
   localparam int CNT_W    = $clog2(INITIAL_INTERVAL + 1);

   sched_state_t         state_q, state_d;
   logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;
   logic [CNT_W-1:0]     interval_q, interval_d;
   logic [COL_W-1:0]     col_q, col_d;
   logic                 sel_first_q, sel_first_d;
   logic [SLOT_W-1:0]    rr_q, rr_d;
   logic [NUM_SLOTS-1:0] fire_start_q, fire_start_d;
   coord_t               fire_x_q, fire_x_d;
   coord_t               fire_y_q, fire_y_d;
   logic [SLOT_W-1:0]    fire_slot_q, fire_slot_d;

   logic [15:0]          lfsr_q;
   logic [COL_W-1:0]     start_col;
   logic [COL_W-1:0]     cand_col;
   logic                 free_found;
   logic [SLOT_W-1:0]    free_slot;
   logic [SLOT_W-1:0]    slot_idx;
   coord_t               fire_x_calc;
   logic                 unused_bits;

   lfsr16 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .seed  (LFSR_SEED),
      .q     (lfsr_q)
   );

`ifdef SHOT_SCHED_AIM_EN
   // Only the parity of the shot count steers the scan start.
   logic                shot_odd_q, shot_odd_d;
   logic signed [11:0]  aim_diff;
   logic signed [11:0]  aim_shift;
   logic [COL_W-1:0]    aim_col;

   assign aim_diff  = $signed({bus.playerXPosition[10], bus.playerXPosition})
                    - $signed({bus.alienBaseX[10], bus.alienBaseX});
   assign aim_shift = aim_diff >>> PITCH_SH;

   always_comb begin
      aim_col = aim_shift[COL_W-1:0];
      if (int'(aim_shift) < 0)                     aim_col = '0;
      else if (int'(aim_shift) > NUM_COLUMNS - 1)  aim_col = COL_W'(NUM_COLUMNS - 1);
   end

   assign unused_bits = ^lfsr_q[15:COL_W];
`else
   assign unused_bits = ^{lfsr_q[15:COL_W], bus.playerXPosition};
`endif

   always_comb begin
      start_col = lfsr_q[COL_W-1:0];
`ifdef SHOT_SCHED_AIM_EN
      if (shot_odd_q) start_col = aim_col;
`endif
   end

   assign cand_col    = sel_first_q ? start_col : col_q;
   assign fire_x_calc = 11'(int'(bus.alienBaseX) + int'(col_q) * COLUMN_PITCH + SHOT_X_OFFSET);
   assign sel_first_d = (state_d == SELECT) && (state_q != SELECT);

   // First free slot searching upward from the round-robin pointer.
   always_comb begin
      free_found = 1'b0;
      free_slot  = '0;
      slot_idx   = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         slot_idx = SLOT_W'((int'(rr_q) + i) % NUM_SLOTS);
         if (!free_found && !bus.slotAlive[slot_idx]) begin
            free_found = 1'b1;
            free_slot  = slot_idx;
         end
      end
   end

   always_comb begin
      interval_d = interval_q;
      if (bus.levelUp) begin
         if (int'(interval_q) < MIN_INTERVAL + INTERVAL_STEP) interval_d = CNT_W'(MIN_INTERVAL);
         else                                                 interval_d = interval_q - CNT_W'(INTERVAL_STEP);
      end
   end

   always_comb begin
      state_d      = state_q;
      frame_cnt_d  = frame_cnt_q;
      col_d        = col_q;
      rr_d         = rr_q;
      fire_start_d = '0;
      fire_x_d     = fire_x_q;
      fire_y_d     = fire_y_q;
      fire_slot_d  = fire_slot_q;
`ifdef SHOT_SCHED_AIM_EN
      shot_odd_d   = shot_odd_q;
`endif
      if (!bus.playGame) begin
         state_d     = IDLE;
         frame_cnt_d = interval_q;
      end else begin
         case (state_q)
            IDLE: begin
               frame_cnt_d = interval_q;
               state_d     = WAIT;
            end
            WAIT: begin
               if (bus.startOfFrame) begin
                  frame_cnt_d = frame_cnt_q - CNT_W'(1);
                  if (frame_cnt_q <= CNT_W'(1)) state_d = SELECT;
               end
            end
            SELECT: begin
               // An empty grid mid-scan also bails out so the scan cannot spin forever.
               if ((sel_first_q && (&bus.slotAlive)) || (bus.aliveColumns == '0)) begin
                  frame_cnt_d = interval_q;
                  state_d     = WAIT;
               end else if (bus.aliveColumns[cand_col]) begin
                  col_d   = cand_col;
                  state_d = FIRE;
               end else begin
                  col_d = cand_col + COL_W'(1);
               end
            end
            FIRE: begin
               if (free_found) begin
                  fire_start_d[free_slot] = 1'b1;
                  fire_x_d    = fire_x_calc;
                  fire_y_d    = bus.alienBottomY;
                  fire_slot_d = free_slot;
                  rr_d        = (int'(free_slot) == NUM_SLOTS - 1) ? '0 : free_slot + SLOT_W'(1);
`ifdef SHOT_SCHED_AIM_EN
                  shot_odd_d  = ~shot_odd_q;
`endif
               end
               frame_cnt_d = interval_q;
               state_d     = WAIT;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         frame_cnt_q  <= CNT_W'(INITIAL_INTERVAL);
         interval_q   <= CNT_W'(INITIAL_INTERVAL);
         col_q        <= '0;
         sel_first_q  <= 1'b0;
         rr_q         <= '0;
         fire_start_q <= '0;
         fire_x_q     <= '0;
         fire_y_q     <= '0;
         fire_slot_q  <= '0;
`ifdef SHOT_SCHED_AIM_EN
         shot_odd_q   <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         frame_cnt_q  <= frame_cnt_d;
         interval_q   <= interval_d;
         col_q        <= col_d;
         sel_first_q  <= sel_first_d;
         rr_q         <= rr_d;
         fire_start_q <= fire_start_d;
         fire_x_q     <= fire_x_d;
         fire_y_q     <= fire_y_d;
         fire_slot_q  <= fire_slot_d;
`ifdef SHOT_SCHED_AIM_EN
         shot_odd_q   <= shot_odd_d;
`endif
      end
   end

   assign bus.fireStart = fire_start_q;
   assign bus.fireX     = fire_x_q;
   assign bus.fireY     = fire_y_q;
   assign bus.fireSlot  = fire_slot_q;

endmodule

// File: tb/tb_alien_shot_scheduler.sv
// Scoreboard bench for alien_shot_scheduler: a frame-level reference model predicts each launch.
module tb_alien_shot_scheduler;
   import shot_sched_pkg::*;

   localparam int          NS      = 3;
   localparam int          NC      = 8;
   localparam int          PITCH   = 64;
   localparam int          OFF     = 28;
   localparam int          INIT_IV = 4;
   localparam int          MIN_IV  = 2;
   localparam int          STEP_IV = 1;
   localparam logic [15:0] SEED    = 16'hACE1;
`ifdef SHOT_SCHED_AIM_EN
   localparam bit AIM_EN = 1'b1;
`else
   localparam bit AIM_EN = 1'b0;
`endif

   typedef struct {
      int         cyc;
      logic [2:0] onehot;
      logic [10:0] x;
      logic [10:0] y;
      logic [1:0] slot;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   alien_shot_scheduler_if #(.NUM_SLOTS(NS), .NUM_COLUMNS(NC)) bus ();

   alien_shot_scheduler #(
      .NUM_SLOTS        (NS),
      .NUM_COLUMNS      (NC),
      .COLUMN_PITCH     (PITCH),
      .SHOT_X_OFFSET    (OFF),
      .INITIAL_INTERVAL (INIT_IV),
      .MIN_INTERVAL     (MIN_IV),
      .INTERVAL_STEP    (STEP_IV),
      .LFSR_SEED        (SEED)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int   total = 0;
   int   bad   = 0;
   exp_t exp_q[$];

   // Clock count since reset release and the spec's LFSR sequence over the same clocks.
   int          edge_cnt;
   logic [15:0] ref_lfsr;
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         edge_cnt <= 0;
         ref_lfsr <= SEED;
      end else begin
         edge_cnt <= edge_cnt + 1;
         ref_lfsr <= {ref_lfsr[14:0], ref_lfsr[15] ^ ref_lfsr[13] ^ ref_lfsr[12] ^ ref_lfsr[10]};
      end
   end

   // Model state at frame/transaction granularity.
   int         m_interval, m_frames, m_rr, m_shots;
   bit         m_play;
   int         cols, busy, base, bottom, player;
   logic [10:0] last_x;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (!reset) begin
         if (bus.fireStart != '0) begin
            if (exp_q.size() == 0) begin
               check("unexpected_fire", {29'd0, bus.fireStart}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("fire_cycle", edge_cnt, e.cyc);
               check("fireStart", {29'd0, bus.fireStart}, {29'd0, e.onehot});
               check("fireX", {21'd0, bus.fireX}, {21'd0, e.x});
               check("fireY", {21'd0, bus.fireY}, {21'd0, e.y});
               check("fireSlot", {30'd0, bus.fireSlot}, {30'd0, e.slot});
            end
         end else if (exp_q.size() > 0 && exp_q[0].cyc <= edge_cnt) begin
            e = exp_q.pop_front();
            check("missing_fire", 32'd0, {29'd0, e.onehot});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive();
      bus.aliveColumns    = 8'(cols);
      bus.slotAlive       = 3'(busy);
      bus.alienBaseX      = 11'(base);
      bus.alienBottomY    = 11'(bottom);
      bus.playerXPosition = 11'(player);
   endtask

   task automatic model_reset();
      m_interval = INIT_IV;
      m_frames   = INIT_IV;
      m_rr       = 0;
      m_shots    = 0;
   endtask

   // Fire attempt decided by the startOfFrame sampled at clock k0; lfsr is its value after k0.
   task automatic attempt(input int k0, input logic [15:0] lfsr);
      int   start, d, col, slot;
      exp_t e;
      m_frames = m_interval;
      if (busy == 7 || cols == 0) return;
      start = lfsr % NC;
      if (AIM_EN && (m_shots % 2 == 1)) begin
         start = (player - base) >>> $clog2(PITCH);
         if (start < 0) start = 0;
         if (start > NC - 1) start = NC - 1;
      end
      d = 0;
      while (((cols >> ((start + d) % NC)) & 1) == 0) d++;
      col  = (start + d) % NC;
      slot = m_rr;
      while (((busy >> slot) & 1) == 1) slot = (slot + 1) % NS;
      e.cyc    = k0 + d + 2;
      e.onehot = 3'(1 << slot);
      e.x      = 11'(base + col * PITCH + OFF);
      e.y      = 11'(bottom);
      e.slot   = 2'(slot);
      exp_q.push_back(e);
      last_x   = e.x;
      m_rr     = (slot + 1) % NS;
      m_shots++;
   endtask

   task automatic send_sof();
      bus.startOfFrame = 1'b1;
      tick();
      bus.startOfFrame = 1'b0;
      if (m_play) begin
         m_frames--;
         if (m_frames == 0) attempt(edge_cnt, ref_lfsr);
      end
   endtask

   task automatic set_play(input bit p);
      bus.playGame = p;
      m_play       = p;
      if (p) m_frames = m_interval;
   endtask

   task automatic level_up();
      bus.levelUp = 1'b1;
      tick();
      bus.levelUp = 1'b0;
      m_interval = (m_interval - STEP_IV < MIN_IV) ? MIN_IV : m_interval - STEP_IV;
   endtask

   task automatic new_inputs();
      cols   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 255));
      busy   = int'($urandom_range(0, 7));
      base   = int'($urandom_range(0, 1000)) - 500;
      bottom = int'($urandom_range(0, 1000)) - 500;
      player = int'($urandom_range(0, 1000)) - 500;
      drive();
   endtask

   // One frame period: optional SOF, quiet time for the attempt, then an input action.
   task automatic run_slot(input bit sof, input int action);
      if (sof) send_sof();
      else     tick();
      repeat (10) tick();
      case (action)
         1: new_inputs();
         2: level_up();
         3: set_play(!m_play);
         default: ;
      endcase
      repeat (3) tick();
   endtask

   initial begin
      int r;
      reset            = 1'b1;
      bus.startOfFrame = 1'b0;
      bus.levelUp      = 1'b0;
      bus.playGame     = 1'b0;
      m_play           = 1'b0;
      last_x           = '0;
      cols = 'h04; busy = 0; base = 100; bottom = 200; player = 300;
      drive();
      model_reset();
      repeat (3) tick();
      check("rst_fireStart", {29'd0, bus.fireStart}, 32'd0);
      check("rst_fireX", {21'd0, bus.fireX}, 32'd0);
      check("rst_fireY", {21'd0, bus.fireY}, 32'd0);
      check("rst_fireSlot", {30'd0, bus.fireSlot}, 32'd0);
      reset = 1'b0;
      tick();

      // Single alive column: 4th frame fires slot 0 at X=256, Y=200.
      set_play(1'b1);
      repeat (2) tick();
      repeat (4) run_slot(1'b1, 0);
      check("held_fireX", {21'd0, bus.fireX}, 32'd256);
      check("held_fireY", {21'd0, bus.fireY}, 32'd200);

      // Busy slots 0/1 force slot 2, then round-robin wraps to slot 0.
      cols = 'hFF; busy = 3; drive();
      repeat (4) run_slot(1'b1, 0);
      busy = 0; drive();
      repeat (4) run_slot(1'b1, 0);

      // All slots alive: the attempt is skipped and retried one interval later.
      busy = 7; drive();
      repeat (4) run_slot(1'b1, 0);
      busy = 0; drive();
      repeat (4) run_slot(1'b1, 0);

      // Interval shrinks to the floor and saturates there.
      repeat (3) level_up();
      repeat (6) run_slot(1'b1, 0);

      // playGame dropped right after the expiring frame: abort with outputs held.
      cols = 'h80; busy = 0; drive();
      while (m_frames > 1) run_slot(1'b1, 0);
      bus.startOfFrame = 1'b1;
      tick();
      bus.startOfFrame = 1'b0;
      set_play(1'b0);
      repeat (12) tick();
      check("abort_state", {30'd0, dut.state_q}, {30'd0, IDLE});
      check("abort_fireX", {21'd0, bus.fireX}, {21'd0, last_x});
      set_play(1'b1);
      repeat (2) tick();

      // Randomized frames.
      for (int n = 0; n < 200; n++) begin
         r = int'($urandom_range(0, 99));
         run_slot($urandom_range(0, 9) != 0,
                  (r < 45) ? 1 : (r < 55) ? 2 : (r < 60) ? 3 : 0);
      end

      // Asynchronous reset in the middle of WAIT.
      if (!m_play) set_play(1'b1);
      cols = 'hFF; busy = 0; base = 100; bottom = 200; player = 300; drive();
      repeat (4) tick();
      check("pending_at_reset", exp_q.size(), 32'd0);
      #2 reset = 1'b1;
      #1;
      check("arst_fireStart", {29'd0, bus.fireStart}, 32'd0);
      check("arst_fireX", {21'd0, bus.fireX}, 32'd0);
      check("arst_fireY", {21'd0, bus.fireY}, 32'd0);
      check("arst_fireSlot", {30'd0, bus.fireSlot}, 32'd0);
      check("arst_state", {30'd0, dut.state_q}, {30'd0, IDLE});
      exp_q.delete();
      tick();
      reset = 1'b0;
      model_reset();
      m_frames = m_interval;
      repeat (2) tick();

      // Post-reset: interval back to its initial value; aim build targets column 3 on shot 2.
      repeat (8) run_slot(1'b1, 0);
      for (int n = 0; n < 40; n++) run_slot($urandom_range(0, 9) != 0, ($urandom_range(0, 1) == 0) ? 1 : 0);

      repeat (20) tick();
      check("drain", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alien_shot_scheduler.md
# alien_shot_scheduler

Sequences alien fire across a fixed pool of alien-shot datapath slots. Each slot is a move/collision instance with a one-cycle `start` input and an `alive` output. On a frame-counted interval, the block picks a free slot round-robin and a firing column that still holds aliens. It then issues a one-cycle start pulse together with the launch coordinates. It sits between the alien-grid controller and the alien shot instances, alongside the player shot path.

## Interface
Parameters:
- `NUM_SLOTS`, default 3: number of alien shot instances (2..4).
- `NUM_COLUMNS`, default 8: alien grid columns; must be a power of two (2..16).
- `COLUMN_PITCH`, default 64: pixel pitch between columns; must be a power of two.
- `SHOT_X_OFFSET`, default 28: X offset of the shot inside a column cell.
- `INITIAL_INTERVAL`, default 60: frames between fire attempts after reset.
- `MIN_INTERVAL`, default 15: lower bound on the interval.
- `INTERVAL_STEP`, default 5: interval decrement applied per `levelUp`.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `startOfFrame` in 1: one-cycle pulse at the start of each frame.
- `playGame` in 1: game-running qualifier.
- `levelUp` in 1: one-cycle pulse that shortens the interval.
- `aliveColumns` in NUM_COLUMNS: bit c is set when column c has at least one alien.
- `alienBaseX` in 11 signed: X of column 0 cell.
- `alienBottomY` in 11 signed: Y of the lowest alien row.
- `playerXPosition` in 11 signed: player X; used only with the aim feature.
- `slotAlive` in NUM_SLOTS: alive flags from the shot instances.
- `fireStart` out NUM_SLOTS: one-hot, one-cycle start pulse to the slot.
- `fireX` out 11 signed: launch X, held until the next fire.
- `fireY` out 11 signed: launch Y, held until the next fire.
- `fireSlot` out $clog2(NUM_SLOTS): index of the last fired slot.

## Operation
States:
- IDLE: entered on reset or whenever `playGame` is 0. Reloads `frameCnt` with `interval`. Moves to WAIT when `playGame` is 1.
- WAIT: each `startOfFrame` decrements `frameCnt`. When a pulse arrives with `frameCnt`==1, the next state is SELECT.
- SELECT, first cycle:
  - If all `slotAlive` bits are 1, or `aliveColumns`==0: reload `frameCnt` and return to WAIT (the attempt is skipped, no pulse).
  - Otherwise `col` = lfsr[log2(NUM_COLUMNS)-1:0].
  - Each SELECT cycle tests `aliveColumns[col]`. If set, go to FIRE. If clear, `col` = `col`+1, wrapping modulo NUM_COLUMNS.
  - The scan finds an alive column within NUM_COLUMNS cycles.
- FIRE, one cycle:
  - Slot = first index with `slotAlive`=0, searching upward from `rrPtr` with wrap. `slotAlive` is sampled in FIRE.
  - Assert `fireStart`[slot].
  - `fireX` = `alienBaseX` + `col`*COLUMN_PITCH + SHOT_X_OFFSET, truncated to 11 bits (two's-complement wrap).
  - `fireY` = `alienBottomY`.
  - `fireSlot` = slot; `rrPtr` = slot+1 with wrap; `shotCount`++.
  - Reload `frameCnt` and go to WAIT.
  - If every slot became alive between SELECT and FIRE, no pulse is issued and `rrPtr` is unchanged.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every clock in every state except under reset.
- `levelUp`, in any state: `interval` = max(MIN_INTERVAL, `interval` − INTERVAL_STEP). The new value takes effect at the next reload. A `levelUp` in the same cycle as a reload updates `interval` only; the reload uses the old value.

Boundaries:
- `startOfFrame` during SELECT or FIRE is not counted.
- `playGame` falling during SELECT or FIRE aborts to IDLE with no `fireStart`. `fireX`/`fireY`/`fireSlot` keep their values.
- `reset` dominates everything.
- `interval` is reinitialised only by `reset`, not by `playGame`.

Reset values: `fireStart`=0, `fireX`=0, `fireY`=0, `fireSlot`=0, state IDLE, `interval`=`frameCnt`=INITIAL_INTERVAL, `rrPtr`=0, `shotCount`=0, lfsr=LFSR_SEED.

## Timing
- `fireStart` is registered and high for exactly one clock.
- `fireX`/`fireY`/`fireSlot` update in the same cycle `fireStart` asserts and are stable from that edge on.
- Latency from the expiring `startOfFrame` to `fireStart`: 2 clocks when the first candidate column is alive, up to NUM_COLUMNS+1 clocks otherwise.
- Consecutive fires are at least `interval` frames apart.
- Zero-latency path: a `slotAlive` bit dropping in FIRE is honoured that same cycle.

## Configuration
- `SHOT_SCHED_AIM_EN` defined: on odd `shotCount`, SELECT starts its scan from `aimCol` instead of the LFSR.
  - `aimCol` = (`playerXPosition` − `alienBaseX`) >>> log2(COLUMN_PITCH), clamped to 0..NUM_COLUMNS−1.
- Not defined: the scan always starts from the LFSR, `playerXPosition` is ignored, and `shotCount` may be optimised away.

## Structure
- Package `shot_sched_pkg` holds:
  - state enum {IDLE, WAIT, SELECT, FIRE};
  - LFSR tap constant and default seed;
  - the 11-bit signed coordinate typedef shared with the shot instances.
- Sub-module `lfsr16`, with ports clk, reset, seed, q[15:0], is natural; the rest stays in one module.

## Test plan
- Defaults with INITIAL_INTERVAL=4, `alienBaseX`=100, `alienBottomY`=200, `aliveColumns`=8'h04, `slotAlive`=0: after the 4th `startOfFrame`, `fireStart`=3'b001 for 1 clock, `fireX`=256, `fireY`=200.
- `slotAlive`=3'b011, `rrPtr`=0, all columns alive: `fireStart`=3'b100, `fireSlot`=2. Next fire with all slots free: `fireStart`=3'b001.
- `slotAlive`=3'b111 at expiry: no `fireStart`; the next attempt occurs `interval` frames later.
- Seven `levelUp` pulses from 60: `interval`=25; fourteen pulses: `interval` saturates at 15.
- `playGame` dropped during SELECT (`aliveColumns`=8'h80, long scan): no `fireStart`, state IDLE. `reset` asserted mid-WAIT: all outputs return to reset values asynchronously.
- With `SHOT_SCHED_AIM_EN`, `playerXPosition`=300, `alienBaseX`=100: the second shot fires from column 3, `fireX`=320.
